// File: rtl/data_generator_pkg.sv
// Shared constants and types for the 256-bit AXI-Stream pattern source and its checker.
// A beat is LANES identical copies of one WORD_W-bit sequence word.
package data_generator_pkg;

   localparam int WORD_W = 16;
   localparam int LANES  = 16;
   localparam int AXIS_W = WORD_W * LANES;

   localparam logic [WORD_W-1:0] CORRUPT_MASK = 16'h0001;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } state_t;

   // The top lane alone is flipped so a checker sees exactly one bad lane.
   function automatic logic [AXIS_W-1:0] build_beat(input logic [WORD_W-1:0] word,
                                                    input logic              corrupt);
      logic [AXIS_W-1:0] beat;
      beat = {LANES{word}};
      if (corrupt) begin
         beat[AXIS_W-1 -: WORD_W] = word ^ CORRUPT_MASK;
      end
      return beat;
   endfunction

endpackage

// File: rtl/data_generator.sv
// AXI-Stream sequence-word source with start/stop control, fixed-length packets,
// single-beat error injection and 32-bit statistics counters.
module data_generator
   import data_generator_pkg::*;
#(
   parameter int                PACKET_BEATS = 128,
   parameter logic [WORD_W-1:0] SEED         = 16'h0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              START,
   input  logic              STOP,
   input  logic              INJECT_ERROR,
   output logic              BUSY,
   output logic [31:0]       BEATS_SENT,
   output logic [31:0]       PACKETS_SENT,
   output logic [31:0]       ERRORS_INJECTED,
   output logic [AXIS_W-1:0] AXIS_TDATA,
   output logic              AXIS_TVALID,
   output logic              AXIS_TLAST,
   input  logic              AXIS_TREADY
);

   localparam logic [15:0] LAST_IDX = 16'(PACKET_BEATS - 1);

   state_t              state_reg;
   logic [WORD_W-1:0]   word_reg;
   logic [15:0]         beat_idx_reg;
   logic                pending_reg;
   logic                corrupt_reg;
   logic                tvalid_reg;
   logic                tlast_reg;
   logic [AXIS_W-1:0]   tdata_reg;
   logic                busy_reg;
   logic [31:0]         beats_reg;
   logic [31:0]         packets_reg;
   logic [31:0]         errors_reg;

   logic                xfer;
   logic                stop_now;
   logic                pending_next;
   logic [WORD_W-1:0]   word_next;
   logic [15:0]         idx_next;

   always_comb begin
      xfer         = tvalid_reg & AXIS_TREADY;
      stop_now     = (state_reg == STOPPING) | STOP;
      pending_next = pending_reg | INJECT_ERROR;
      word_next    = word_reg + 16'd1;
      idx_next     = tlast_reg ? 16'd0 : beat_idx_reg + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         word_reg     <= SEED;
         beat_idx_reg <= 16'd0;
         pending_reg  <= 1'b0;
         corrupt_reg  <= 1'b0;
         tvalid_reg   <= 1'b0;
         tlast_reg    <= 1'b0;
         tdata_reg    <= {LANES{SEED}};
         busy_reg     <= 1'b0;
         beats_reg    <= 32'd0;
         packets_reg  <= 32'd0;
         errors_reg   <= 32'd0;
      end else begin
         if (xfer) begin
            beats_reg   <= beats_reg + 32'd1;
            packets_reg <= packets_reg + {31'd0, tlast_reg};
            errors_reg  <= errors_reg + {31'd0, corrupt_reg};
         end

         case (state_reg)
            IDLE: begin
               if (START) begin
                  state_reg    <= RUN;
                  busy_reg     <= 1'b1;
                  tvalid_reg   <= 1'b1;
                  beat_idx_reg <= 16'd0;
                  tlast_reg    <= (LAST_IDX == 16'd0);
                  tdata_reg    <= build_beat(word_reg, pending_next);
                  corrupt_reg  <= pending_next;
                  pending_reg  <= 1'b0;
               end else begin
                  pending_reg  <= pending_next;
               end
            end

            RUN, STOPPING: begin
               if (xfer) begin
                  word_reg     <= word_next;
                  beat_idx_reg <= idx_next;
                  if (tlast_reg && stop_now) begin
                     // No beat follows, so any pending corruption waits for the next START.
                     state_reg   <= IDLE;
                     busy_reg    <= 1'b0;
                     tvalid_reg  <= 1'b0;
                     tlast_reg   <= 1'b0;
                     corrupt_reg <= 1'b0;
                     tdata_reg   <= build_beat(word_next, 1'b0);
                     pending_reg <= pending_next;
                  end else begin
                     state_reg   <= stop_now ? STOPPING : RUN;
                     tlast_reg   <= (idx_next == LAST_IDX);
                     tdata_reg   <= build_beat(word_next, pending_next);
                     corrupt_reg <= pending_next;
                     pending_reg <= 1'b0;
                  end
               end else begin
                  pending_reg <= pending_next;
                  if (stop_now) begin
                     state_reg <= STOPPING;
                  end
               end
            end

            default: begin
               state_reg  <= IDLE;
               busy_reg   <= 1'b0;
               tvalid_reg <= 1'b0;
               tlast_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY            = busy_reg;
   assign BEATS_SENT      = beats_reg;
   assign PACKETS_SENT    = packets_reg;
   assign ERRORS_INJECTED = errors_reg;
   assign AXIS_TDATA      = tdata_reg;
   assign AXIS_TVALID     = tvalid_reg;
   assign AXIS_TLAST      = tlast_reg;

endmodule

// File: tb/tb_data_generator.sv
// Directed bench for data_generator: two instances (SEED 0 and SEED FFFE), 4-beat packets.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_data_generator;

   logic         clock = 1'b0;
   logic         reset_a, start_a, stop_a, inject_a, tready_a;
   logic         busy_a, tvalid_a, tlast_a;
   logic [31:0]  beats_a, packets_a, errors_a;
   logic [255:0] tdata_a;

   logic         reset_b, start_b, stop_b, inject_b, tready_b;
   logic         busy_b, tvalid_b, tlast_b;
   logic [31:0]  beats_b, packets_b, errors_b;
   logic [255:0] tdata_b;

   int checks = 0;
   int errors = 0;
   logic [255:0] exp_beat;

   always #5 clock = ~clock;

   data_generator #(.PACKET_BEATS(4), .SEED(16'h0000)) dut_a (
      .clock(clock), .reset(reset_a), .START(start_a), .STOP(stop_a),
      .INJECT_ERROR(inject_a), .BUSY(busy_a), .BEATS_SENT(beats_a),
      .PACKETS_SENT(packets_a), .ERRORS_INJECTED(errors_a), .AXIS_TDATA(tdata_a),
      .AXIS_TVALID(tvalid_a), .AXIS_TLAST(tlast_a), .AXIS_TREADY(tready_a)
   );

   data_generator #(.PACKET_BEATS(4), .SEED(16'hFFFE)) dut_b (
      .clock(clock), .reset(reset_b), .START(start_b), .STOP(stop_b),
      .INJECT_ERROR(inject_b), .BUSY(busy_b), .BEATS_SENT(beats_b),
      .PACKETS_SENT(packets_b), .ERRORS_INJECTED(errors_b), .AXIS_TDATA(tdata_b),
      .AXIS_TVALID(tvalid_b), .AXIS_TLAST(tlast_b), .AXIS_TREADY(tready_b)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Number of lanes that differ from the expected word, as the downstream checker would count.
   function automatic int lane_errs(input logic [255:0] d, input logic [15:0] w);
      int n = 0;
      for (int i = 0; i < 16; i++) if (d[i*16 +: 16] != w) n++;
      return n;
   endfunction

   task automatic chk_beat_a(input string tag, input logic [15:0] w, input logic last,
                             input logic [31:0] beats);
      chk({tag, "_tdata"}, tdata_a, {16{w}});
      chk({tag, "_tvalid"}, {255'd0, tvalid_a}, 256'd1);
      chk({tag, "_tlast"}, {255'd0, tlast_a}, {255'd0, last});
      chk({tag, "_beats"}, {224'd0, beats_a}, {224'd0, beats});
      $display("beat %s word=%04h last=%0b beats=%0d", tag, tdata_a[15:0], tlast_a, beats_a);
   endtask

   initial begin
      reset_a = 1; start_a = 0; stop_a = 0; inject_a = 0; tready_a = 1;
      reset_b = 1; start_b = 0; stop_b = 0; inject_b = 0; tready_b = 1;
      step(); step();

      chk("rst_tvalid", {255'd0, tvalid_a}, 256'd0);
      chk("rst_tlast",  {255'd0, tlast_a},  256'd0);
      chk("rst_busy",   {255'd0, busy_a},   256'd0);
      chk("rst_tdata",  tdata_a, {16{16'h0000}});
      chk("rst_cnt",    {160'd0, beats_a, packets_a, errors_a}, 256'd0);
      chk("rst_tdata_b", tdata_b, {16{16'hFFFE}});

      reset_a = 0; reset_b = 0;
      step();
      chk("idle_tvalid", {255'd0, tvalid_a}, 256'd0);

      // First packet at full rate
      start_a = 1; step(); start_a = 0;
      chk("start_busy", {255'd0, busy_a}, 256'd1);
      chk_beat_a("w0", 16'h0000, 1'b0, 32'd0);
      step(); chk_beat_a("w1", 16'h0001, 1'b0, 32'd1);
      step(); chk_beat_a("w2", 16'h0002, 1'b0, 32'd2);

      // Backpressure holds word 2
      tready_a = 0;
      for (int i = 0; i < 5; i++) begin
         step(); chk_beat_a("w2_hold", 16'h0002, 1'b0, 32'd2);
      end
      tready_a = 1;
      step(); chk_beat_a("w3", 16'h0003, 1'b1, 32'd3);
      step(); chk_beat_a("w4", 16'h0004, 1'b0, 32'd4);
      chk("pkt1", {224'd0, packets_a}, 256'd1);
      step(); chk_beat_a("w5", 16'h0005, 1'b0, 32'd5);

      // Inject while word 5 stalls, then STOP at beat index 1
      tready_a = 0; inject_a = 1;
      step(); inject_a = 0;
      chk_beat_a("w5_inj_hold", 16'h0005, 1'b0, 32'd5);
      stop_a = 1;
      step(); stop_a = 0;
      chk_beat_a("w5_stop_hold", 16'h0005, 1'b0, 32'd5);
      chk("stopping_busy", {255'd0, busy_a}, 256'd1);
      tready_a = 1;
      step();
      exp_beat = {16{16'h0006}};
      exp_beat[255:240] = 16'h0007;
      chk("w6_corrupt", tdata_a, exp_beat);
      chk("w6_lane_errs", 256'(lane_errs(tdata_a, 16'h0006)), 256'd1);
      chk("w6_errs_cnt", {224'd0, errors_a}, 256'd0);
      $display("beat w6 top=%04h low=%04h errs=%0d", tdata_a[255:240], tdata_a[15:0], errors_a);
      step(); chk_beat_a("w7", 16'h0007, 1'b1, 32'd7);
      chk("w7_errs_cnt", {224'd0, errors_a}, 256'd1);
      step();
      chk("stop_tvalid", {255'd0, tvalid_a}, 256'd0);
      chk("stop_busy",   {255'd0, busy_a},   256'd0);
      chk("stop_pkts",   {224'd0, packets_a}, 256'd2);
      chk("stop_beats",  {224'd0, beats_a},   256'd8);
      step();
      chk("idle2_tvalid", {255'd0, tvalid_a}, 256'd0);

      // Two pulses in IDLE merge into one corrupt beat at START
      inject_a = 1; step(); step(); inject_a = 0;
      start_a = 1; step(); start_a = 0;
      exp_beat = {16{16'h0008}};
      exp_beat[255:240] = 16'h0009;
      chk("w8_corrupt", tdata_a, exp_beat);
      $display("beat w8 top=%04h low=%04h", tdata_a[255:240], tdata_a[15:0]);
      step(); chk_beat_a("w9_clean", 16'h0009, 1'b0, 32'd9);
      chk("w9_errs_cnt", {224'd0, errors_a}, 256'd2);
      step(); chk_beat_a("w10", 16'h000A, 1'b0, 32'd10);
      step(); chk_beat_a("w11", 16'h000B, 1'b1, 32'd11);

      // STOP coincides with the TLAST transfer: straight to IDLE
      stop_a = 1; step(); stop_a = 0;
      chk("stoplast_tvalid", {255'd0, tvalid_a}, 256'd0);
      chk("stoplast_busy",   {255'd0, busy_a},   256'd0);
      chk("stoplast_pkts",   {224'd0, packets_a}, 256'd3);
      step(); step();
      chk("stoplast_noextra", {192'd0, beats_a, packets_a}, {192'd0, 32'd12, 32'd3});
      chk("stoplast_errs", {224'd0, errors_a}, 256'd2);

      // Restart continues the word sequence
      start_a = 1; stop_a = 1; step(); start_a = 0; stop_a = 0;
      chk_beat_a("w12", 16'h000C, 1'b0, 32'd12);
      chk("restart_busy", {255'd0, busy_a}, 256'd1);

      // Asynchronous reset mid-packet, sampled between edges
      #2 reset_a = 1;
      #1;
      chk("arst_tvalid", {255'd0, tvalid_a}, 256'd0);
      chk("arst_tlast",  {255'd0, tlast_a},  256'd0);
      chk("arst_busy",   {255'd0, busy_a},   256'd0);
      chk("arst_tdata",  tdata_a, {16{16'h0000}});
      chk("arst_cnt",    {160'd0, beats_a, packets_a, errors_a}, 256'd0);
      $display("async reset tvalid=%0b beats=%0d", tvalid_a, beats_a);
      reset_a = 0;

      // SEED FFFE wraps through 0000
      step();
      start_b = 1; step(); start_b = 0;
      chk("b_w0", tdata_b, {16{16'hFFFE}});
      step(); chk("b_w1", tdata_b, {16{16'hFFFF}});
      step(); chk("b_w2", tdata_b, {16{16'h0000}});
      step(); chk("b_w3", tdata_b, {16{16'h0001}});
      chk("b_w3_last", {255'd0, tlast_b}, 256'd1);
      chk("b_beats", {224'd0, beats_b}, 256'd3);
      $display("seed_b word=%04h last=%0b beats=%0d", tdata_b[15:0], tlast_b, beats_b);
      step();
      chk("b_pkts", {224'd0, packets_b}, 256'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
